// File: rtl/v6502_pkg.sv
// Shared 6502 core constants: byte width and maximum instruction length.
package v6502_pkg;
    localparam int MAX_INST_LEN = 3;
    localparam int BYTE_W       = 8;

    typedef logic [1:0] inst_len_t;
endpackage

// File: rtl/inst_prefetch_queue.sv
// Circular byte FIFO between fetch and decode with a PEEK-byte head window,
// variable-length retire, flush and illegal-pop reporting.
module inst_prefetch_queue
    import v6502_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int DEPTH  = 16,
    parameter int PEEK   = MAX_INST_LEN,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LEN_W = $clog2(PEEK + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    input  logic [DATA_W-1:0]      push_data,
    output logic                   push_ready,
    input  logic                   pop_en,
    input  logic [LEN_W-1:0]       pop_len,
    input  logic                   flush,
    output logic [PEEK*DATA_W-1:0] head_data,
    output logic [LEN_W-1:0]       head_count,
    output logic [PTR_W:0]         count,
    output logic                   empty,
    output logic                   full,
    output logic                   pop_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    pop_len_ext;
    logic [PTR_W:0]    pop_amt;
    logic              push_fire;
    logic              pop_fire;
    logic              pop_bad;
    logic              len_over_peek;

    assign full          = (count == (PTR_W+1)'(DEPTH));
    assign empty         = (count == '0);
    assign push_ready    = !full && !flush;
    assign pop_len_ext   = (PTR_W+1)'(pop_len);
    assign len_over_peek = (pop_len > LEN_W'(PEEK));

    assign push_fire = push_valid && push_ready && !rst;
    assign pop_fire  = pop_en && (pop_len != '0) && (pop_len_ext <= count)
                       && !len_over_peek && !flush;
    assign pop_bad   = pop_en && ((pop_len_ext > count) || len_over_peek) && !flush;
    assign pop_amt   = pop_fire ? pop_len_ext : '0;

    assign head_count = (count >= (PTR_W+1)'(PEEK)) ? LEN_W'(PEEK) : count[LEN_W-1:0];

    // Pointer, occupancy and error state; flush outranks every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pop_err <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pop_err <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(pop_len);
            end
            count   <= count + (PTR_W+1)'(push_fire) - pop_amt;
            pop_err <= pop_bad;
        end
    end

    // Storage is never reset; only accepted pushes write it.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head window lanes wrap across the array end; lanes past occupancy read 0.
    for (genvar i = 0; i < PEEK; i++) begin : g_head
        logic [PTR_W-1:0] lane_addr;
        assign lane_addr = rd_ptr + PTR_W'(i);
        assign head_data[i*DATA_W +: DATA_W] =
            (count > (PTR_W+1)'(i)) ? mem[lane_addr] : '0;
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed and randomized bench for inst_prefetch_queue against a queue-based model.
module tb_inst_prefetch_queue;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PEEK   = 3;
    localparam int PTR_W  = 4;
    localparam int LEN_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   push_valid;
    logic [DATA_W-1:0]      push_data;
    logic                   push_ready;
    logic                   pop_en;
    logic [LEN_W-1:0]       pop_len;
    logic                   flush;
    logic [PEEK*DATA_W-1:0] head_data;
    logic [LEN_W-1:0]       head_count;
    logic [PTR_W:0]         count;
    logic                   empty;
    logic                   full;
    logic                   pop_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit         err_exp;

    inst_prefetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_en     (pop_en),
        .pop_len    (pop_len),
        .flush      (flush),
        .head_data  (head_data),
        .head_count (head_count),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .pop_err    (pop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lane(input int i);
        return head_data[i*DATA_W +: DATA_W];
    endfunction

    // Compare every visible output against the model's byte queue.
    task automatic check_state();
        int n;
        n = q.size();
        check("count", 64'(count), 64'(n));
        check("empty", 64'(empty), 64'(n == 0));
        check("full", 64'(full), 64'(n == DEPTH));
        check("head_count", 64'(head_count), 64'((n < PEEK) ? n : PEEK));
        check("pop_err", 64'(pop_err), 64'(err_exp));
        for (int i = 0; i < PEEK; i++) begin
            check($sformatf("lane%0d", i), 64'(lane(i)), 64'((i < n) ? q[i] : 8'h00));
        end
    endtask

    // One clock: drive at negedge, check push_ready, update model at posedge, check after.
    task automatic cycle(input bit pv, input logic [7:0] pd, input bit pe, input int pl,
                         input bit fl, input bit r);
        int  n;
        bit  legal;
        bit  bad;
        logic [7:0] tmp;
        push_valid = pv;
        push_data  = pd;
        pop_en     = pe;
        pop_len    = LEN_W'(pl);
        flush      = fl;
        rst        = r;
        #1;
        check("push_ready", 64'(push_ready), 64'(!fl && (q.size() < DEPTH)));
        @(posedge clk);
        n = q.size();
        if (r || fl) begin
            q.delete();
            err_exp = 1'b0;
        end else begin
            legal = pe && (pl != 0) && (pl <= n) && (pl <= PEEK);
            bad   = pe && ((pl > n) || (pl > PEEK));
            if (legal) begin
                for (int k = 0; k < pl; k++) tmp = q.pop_front();
            end
            if (pv && (n < DEPTH)) q.push_back(pd);
            err_exp = bad;
        end
        #1;
        check_state();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_data = '0; pop_en = 1'b0; pop_len = '0; flush = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1'b1, 8'h55, 1'b0, 0, 1'b0, 1'b1);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_head", 64'(head_data), 64'd0);

        // Test 1: push A9,05,8D
        push(8'hA9); push(8'h05); push(8'h8D);
        check("t1_count", 64'(count), 64'd3);
        check("t1_lane0", 64'(lane(0)), 64'hA9);
        check("t1_lane1", 64'(lane(1)), 64'h05);
        check("t1_lane2", 64'(lane(2)), 64'h8D);

        // Test 2: fill 00..0F, 17th push ignored
        cycle(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_full", 64'(full), 64'd1);
        check("t2_ready", 64'(push_ready), 64'd0);
        push(8'hFF);
        check("t2_count", 64'(count), 64'd16);

        // Test 3: pop 3 from full while pushing 10 (no space freed for it)
        cycle(1'b1, 8'h10, 1'b1, 3, 1'b0, 1'b0);
        check("t3_count", 64'(count), 64'd13);
        check("t3_lane0", 64'(lane(0)), 64'h03);
        push(8'h10);
        check("t3_count2", 64'(count), 64'd14);

        // Test 4: rd_ptr to 14, then wrap across the array end
        cycle(1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0);
        push(8'h11);
        check("t4_count", 64'(count), 64'd4);
        check("t4_lane0", 64'(lane(0)), 64'h0E);
        check("t4_lane1", 64'(lane(1)), 64'h0F);
        check("t4_lane2", 64'(lane(2)), 64'h10);
        cycle(1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0);
        check("t4_wrap_lane0", 64'(lane(0)), 64'h11);

        // Test 5: illegal pop with count=2
        push(8'h22);
        cycle(1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0);
        check("t5_err", 64'(pop_err), 64'd1);
        check("t5_count", 64'(count), 64'd2);
        idle();
        check("t5_err_clr", 64'(pop_err), 64'd0);
        cycle(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        check("t5_len0", 64'(pop_err), 64'd0);

        // Test 6: flush with push and pop at count=9
        for (int i = 0; i < 7; i++) push(8'(8'h30 + i));
        check("t6_pre", 64'(count), 64'd9);
        cycle(1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        cycle(1'b1, 8'hEE, 1'b1, 3, 1'b1, 1'b0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        cycle(1'b1, 8'h66, 1'b0, 0, 1'b0, 1'b1);
        check("t6_rst", 64'(count), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 60) == 0),
                  1'($urandom_range(0, 400) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
